four_to_one_arb_mux: RTL and testbench
======================================

FOUR_TO_ONE_ARB_MUX -- requirements
Module: four_to_one_arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, payload bit width of every lane and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  4  per-lane request; bit i = lane i (lane 0..3 = a,b,c,d).
REQ-005 in_data  input  4*WIDTH  lane payloads; lane i at bits [i*WIDTH +: WIDTH].
REQ-006 in_ready  output  4  per-lane accept; at most one bit high per cycle.
REQ-007 out_valid  output  1  registered output beat present.
REQ-008 out_data  output  WIDTH  registered payload of the granted lane.
REQ-009 out_sel  output  2  source lane code; bit0 = s0, bit1 = s1 (a=00, b=01, c=10, d=11).
REQ-010 out_ready  input  1  downstream accept.

Function
REQ-011 Lane i transfer SHALL occur in a cycle where in_valid[i] & in_ready[i].
REQ-012 Output transfer SHALL occur in a cycle where out_valid & out_ready.
REQ-013 Load condition: load = ~out_valid | out_ready.
REQ-014 in_ready[g] SHALL be 1 only for the granted lane g, and only when load is 1 and in_valid[g] is 1; other bits 0.
REQ-015 Grant SHALL be combinational from in_valid and the priority pointer; no grant when in_valid == 0.
REQ-016 On a lane transfer: out_data <= lane g payload, out_sel <= g, out_valid <= 1; latency exactly 1 cycle input-to-output.
REQ-017 On an output transfer with no lane transfer in the same cycle, out_valid SHALL go 0; out_data/out_sel hold.
REQ-018 Simultaneous output and lane transfer SHALL replace the beat with no bubble (full throughput, one beat per cycle).
REQ-019 While out_valid & ~out_ready: out_valid, out_data, out_sel SHALL be stable; in_ready SHALL be 0.
REQ-020 Pointer update on each lane transfer: ptr <= (g + 1) mod 4 (wraps 3 -> 0); no update otherwise.
REQ-021 Arbitration order: search lanes ptr, ptr+1, ptr+2, ptr+3 (mod 4); first valid lane wins.
REQ-022 Once a lane asserts in_valid it SHALL be granted within 4 lane transfers (round-robin builds only).
REQ-023 No beat SHALL be dropped or duplicated.

Reset
REQ-024 On rst_n low, asynchronously: out_valid = 0, out_data = 0, out_sel = 2'b00, ptr = 0.
REQ-025 Reset mid-operation SHALL discard any held beat; in_ready = 0 while rst_n is low.
REQ-026 First grant after reset SHALL favour lane 0.

Configuration
REQ-027 Macro FOUR_TO_ONE_RR_ARB_EN defined: round-robin arbitration per REQ-020..022.
REQ-028 Macro undefined: fixed priority, lane 0 highest, lane 3 lowest; ptr held at 0; REQ-022 does not apply.

Structure
REQ-029 Shared package four_to_one_arb_pkg: NUM_LANES = 4, lane select typedef (2 bits), lane codes LANE_A..LANE_D.
REQ-030 Sub-module rr_arbiter_4: in_valid + ptr in, one-hot grant + encoded grant out; the top holds the output register and pointer.

Verification
REQ-031 Reset: rst_n low mid-beat -> out_valid = 0, out_sel = 00, out_data = 0 immediately, without waiting for a clock edge.
REQ-032 Single lane: only lane c valid with data 8'h5A, out_ready = 1 -> next cycle out_valid = 1, out_data = 8'h5A, out_sel = 10.
REQ-033 All four lanes valid continuously, out_ready = 1, RR build -> out_sel sequence 00, 01, 10, 11, 00; one beat per cycle.
REQ-034 Backpressure: beat from lane b held with out_ready = 0 for 3 cycles -> out_data/out_sel stable, in_ready = 0000; beat released on the cycle out_ready = 1.
REQ-035 Fixed-priority build, lanes a and d valid continuously -> out_sel stays 00; lane d is never granted.
REQ-036 Pointer wrap: last grant lane d, then lanes a and c valid -> lane a granted first (out_sel = 00).

Source files
------------

// File: rtl/four_to_one_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | four_to_one_arb_pkg                                                       |
// | Shared lane count, lane select type and lane codes for the 4:1 arb mux.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package four_to_one_arb_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_sel_t;

    localparam lane_sel_t LANE_A = 2'b00;
    localparam lane_sel_t LANE_B = 2'b01;
    localparam lane_sel_t LANE_C = 2'b10;
    localparam lane_sel_t LANE_D = 2'b11;

    // Modulo-4 successor falls out of the 2-bit width.
    function automatic lane_sel_t next_lane(input lane_sel_t lane);
        return lane + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter_4                                                              |
// | Combinational 4-way arbiter: first valid lane searching from i_ptr.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter_4
    import four_to_one_arb_pkg::*;
(
    input  logic [NUM_LANES-1:0] i_valid,
    input  lane_sel_t            i_ptr,
    output logic [NUM_LANES-1:0] o_grant_oh,
    output lane_sel_t            o_grant_sel,
    output logic                 o_grant_any
);

    always_comb begin
        o_grant_oh  = '0;
        o_grant_sel = LANE_A;
        o_grant_any = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_sel_t w_idx;
            w_idx = i_ptr + k[1:0];
            if (!o_grant_any && i_valid[w_idx]) begin
                o_grant_oh[w_idx] = 1'b1;
                o_grant_sel       = w_idx;
                o_grant_any       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/four_to_one_arb_mux.sv
// +--------------------------------------------------------------------------+
// | four_to_one_arb_mux                                                       |
// | 4:1 arbitrated mux with a single registered output beat.                  |
// | FOUR_TO_ONE_RR_ARB_EN: defined = round-robin, undefined = fixed priority. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module four_to_one_arb_mux
    import four_to_one_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_LANES-1:0]       in_valid,
    input  logic [NUM_LANES*WIDTH-1:0] in_data,
    output logic [NUM_LANES-1:0]       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [1:0]                 out_sel,
    input  logic                       out_ready
);

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    lane_sel_t            r_out_sel;

    lane_sel_t            w_ptr;
    logic [NUM_LANES-1:0] w_grant_oh;
    lane_sel_t            w_grant_sel;
    logic                 w_grant_any;
    logic                 w_load;
    logic                 w_xfer;
    logic [WIDTH-1:0]     w_grant_data;

    rr_arbiter_4 u_arb (
        .i_valid     (in_valid),
        .i_ptr       (w_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_sel (w_grant_sel),
        .o_grant_any (w_grant_any)
    );

`ifdef FOUR_TO_ONE_RR_ARB_EN
    lane_sel_t r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= LANE_A;
        end else if (w_xfer) begin
            r_ptr <= next_lane(w_grant_sel);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = LANE_A;
`endif

    assign w_load = ~r_out_valid | out_ready;
    assign w_xfer = w_grant_any & w_load;

    // Gating with rst_n keeps in_ready low during reset even though load is 1.
    assign in_ready = (w_load && rst_n) ? w_grant_oh : '0;

    always_comb begin
        w_grant_data = in_data[WIDTH-1:0];
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_grant_sel == lane_sel_t'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= LANE_A;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_sel   <= w_grant_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_four_to_one_arb_mux.sv
// +--------------------------------------------------------------------------+
// | tb_four_to_one_arb_mux                                                    |
// | Self-checking bench for four_to_one_arb_mux; follows FOUR_TO_ONE_RR_ARB_EN.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_four_to_one_arb_mux;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;

    int n_vec;
    int n_err;

    // Reference state: the single pending output beat and the priority start.
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       m_sel;
    int               m_ptr;

    four_to_one_arb_mux #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic step();
        logic       load;
        int         g;
        logic [3:0] exp_rdy;
        #1;
        load    = !m_valid || out_ready;
        g       = load ? pick(in_valid, m_ptr) : -1;
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        n_vec++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
        end
        n_vec++;
        if (out_valid !== m_valid) begin
            n_err++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_valid);
        end
        n_vec++;
        if (out_data !== m_data || out_sel !== m_sel) begin
            n_err++;
            $display("FAIL out_beat: got %h/%b expected %h/%b", out_data, out_sel, m_data, m_sel);
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_sel   = 2'(g);
`ifdef FOUR_TO_ONE_RR_ARB_EN
            m_ptr   = (g + 1) % 4;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_sel     = 2'b00;
        m_ptr     = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n    = 1'b0;
        in_valid = 4'b1111;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'b00) begin
            n_err++;
            $display("FAIL reset_out: got %b/%h/%b expected 0/00/00", out_valid, out_data, out_sel);
        end
        n_vec++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        do_reset();
    endtask

    task automatic test_single_lane();
        do_reset();
        in_valid  = 4'b0100;
        in_data   = 32'h115A_2233;
        out_ready = 1'b1;
        step();
        in_valid = 4'b0000;
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sel !== 2'b10) begin
            n_err++;
            $display("FAIL single_lane: got %b/%h/%b expected 1/5a/10", out_valid, out_data, out_sel);
        end
        step();
    endtask

    task automatic test_all_lanes();
        logic [1:0] exp_seq [5];
`ifdef FOUR_TO_ONE_RR_ARB_EN
        exp_seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
`else
        exp_seq = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
        do_reset();
        in_valid  = 4'b1111;
        in_data   = 32'hD4C3_B2A1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_sel !== exp_seq[i]) begin
                n_err++;
                $display("FAIL all_lanes[%0d]: got %b/%b expected 1/%b", i, out_valid, out_sel, exp_seq[i]);
            end
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid  = 4'b0010;
        in_data   = 32'h0000_B700;
        out_ready = 1'b1;
        step();
        in_valid  = 4'b1111;
        in_data   = 32'h4433_2211;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'hB7 || out_sel !== 2'b01 || in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL backpressure[%0d]: got %b/%h/%b rdy %b expected 1/b7/01 rdy 0000",
                         i, out_valid, out_data, out_sel, in_ready);
            end
            step();
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        step();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'hB7 || out_sel !== 2'b01) begin
            n_err++;
            $display("FAIL release: got %b/%h/%b expected 0/b7/01", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_priority();
        do_reset();
        in_valid  = 4'b1001;
        in_data   = 32'hDD00_00AA;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            #1;
            n_vec++;
`ifdef FOUR_TO_ONE_RR_ARB_EN
            if (out_sel !== ((i % 2 == 0) ? 2'b00 : 2'b11)) begin
`else
            if (out_sel !== 2'b00) begin
`endif
                n_err++;
                $display("FAIL priority[%0d]: got sel %b", i, out_sel);
            end
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid  = 4'b1000;
        in_data   = 32'h0D0C_0B0A;
        out_ready = 1'b1;
        step();
        in_valid = 4'b0101;
        step();
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_sel !== 2'b00 || out_data !== 8'h0A) begin
            n_err++;
            $display("FAIL wrap: got %b/%b/%h expected 1/00/0a", out_valid, out_sel, out_data);
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid  = 4'b0010;
        in_data   = 32'h0000_6600;
        out_ready = 1'b0;
        step();
        in_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'b00 || in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset: got %b/%h/%b rdy %b expected 0/00/00 rdy 0000",
                     out_valid, out_data, out_sel, in_ready);
        end
        do_reset();
        in_valid  = 4'b1010;
        in_data   = 32'h7700_5500;
        out_ready = 1'b1;
        step();
        #1;
        n_vec++;
        if (out_sel !== 2'b01 || out_data !== 8'h55) begin
            n_err++;
            $display("FAIL first_grant: got %b/%h expected 01/55", out_sel, out_data);
        end
        in_valid = 4'b0000;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_backpressure();
        test_priority();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
